// File: rtl/fsm_rd_086_pkg.sv
// Shared definitions for the fsm_rd_086 controller family: state encoding,
// output codes and the transition/output functions of the 7-state graph.
package fsm_rd_086_pkg;

  localparam int unsigned ST_W = 3;
  localparam int unsigned PT_W = 2;
  localparam int unsigned RT_W = 3;

  typedef enum logic [ST_W-1:0] {
    S1   = 3'd0,
    S2   = 3'd1,
    S2N  = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    S5N  = 3'd6,
    HUNT = 3'd7
  } state_e;

  localparam logic [RT_W-1:0] OUT_ZERO = 3'b000;
  localparam logic [RT_W-1:0] OUT_S2N  = 3'b001;
  localparam logic [RT_W-1:0] OUT_S3   = 3'b010;
  localparam logic [RT_W-1:0] OUT_S45  = 3'b100;

  // Next state of the controller graph; encoding 7 behaves like S1.
  function automatic state_e next_state(input state_e st, input logic [PT_W-1:0] ptext);
    state_e nxt;
    nxt = S2;
    case (st)
      S1:      nxt = S2;
      S2:      nxt = ptext[0] ? S3 : S2N;
      S2N:     nxt = ptext[0] ? S3 : S2;
      S3:      nxt = S4;
      S4:      nxt = ptext[1] ? S5 : S3;
      S5:      nxt = ptext[0] ? S1 : S5N;
      S5N:     nxt = ptext[0] ? S1 : S5;
      default: nxt = S2;
    endcase
    return nxt;
  endfunction

  // Moore output of a state; HUNT (and the illegal code) reads as zero.
  function automatic logic [RT_W-1:0] state_out(input state_e st);
    logic [RT_W-1:0] o;
    o = OUT_ZERO;
    case (st)
      S1, S2:       o = OUT_ZERO;
      S2N:          o = OUT_S2N;
      S3:           o = OUT_S3;
      S4, S5, S5N:  o = OUT_S45;
      default:      o = OUT_ZERO;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/fsm_rd_086_errcnt.sv
// Saturating mismatch counter with a sticky threshold alarm and a clear.
module fsm_rd_086_errcnt #(
  parameter int unsigned ERR_W     = 8,
  parameter int unsigned ALARM_THR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [ERR_W-1:0] err_cnt,
  output logic             alarm
);

  localparam logic [ERR_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_W-1:0] THR     = ERR_W'(ALARM_THR);

  logic [ERR_W-1:0] cnt_inc;

  // Incremented count, pinned at all-ones.
  assign cnt_inc = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + ERR_W'(1);

  // Counter and alarm; clear outranks a coincident increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
      alarm   <= 1'b0;
    end else if (clr) begin
      err_cnt <= '0;
      alarm   <= 1'b0;
    end else if (inc) begin
      err_cnt <= cnt_inc;
      if (cnt_inc >= THR) alarm <= 1'b1;
    end
  end

endmodule

// File: rtl/fsm_rd_086_chk.sv
// Observer for an fsm_rd_086 controller: runs a shadow copy of the graph,
// compares its predicted output with the observed rtext and, optionally,
// hunts for the unique S3 output to re-lock after a divergence.
module fsm_rd_086_chk
  import fsm_rd_086_pkg::*;
#(
  parameter int unsigned ERR_W     = 8,
  parameter int unsigned ALARM_THR = 4,
  parameter int unsigned RESYNC    = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [1:0]       ptext,
  input  logic [2:0]       rtext,
  input  logic             clr,
  output logic [2:0]       exp_rtext,
  output logic             mismatch,
  output logic             alarm,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked,
  output logic [2:0]       shadow_st
);

  state_e shadow;
  logic   fail;

  // Prediction straight from the shadow register.
  assign exp_rtext = state_out(shadow);
  assign shadow_st = shadow;

  // A compare happens only on enabled cycles while the shadow is trusted.
  assign fail = en && locked && (rtext != exp_rtext);

  // Shadow state machine, lock flag and registered mismatch pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow   <= S1;
      locked   <= 1'b1;
      mismatch <= 1'b0;
    end else if (!en) begin
      mismatch <= 1'b0;
    end else begin
      mismatch <= fail;
      if (!locked) begin
        // 010 is emitted only from S3, so the controller is now in S4.
        if (rtext == OUT_S3) begin
          shadow <= S4;
          locked <= 1'b1;
        end
      end else if (fail && (RESYNC != 0)) begin
        shadow <= HUNT;
        locked <= 1'b0;
      end else begin
        shadow <= next_state(shadow, ptext);
      end
    end
  end

  fsm_rd_086_errcnt #(
    .ERR_W     (ERR_W),
    .ALARM_THR (ALARM_THR)
  ) u_errcnt (
    .clk     (CLK),
    .rst     (RST),
    .inc     (fail),
    .clr     (clr),
    .err_cnt (err_cnt),
    .alarm   (alarm)
  );

endmodule

// File: tb/tb_fsm_rd_086_chk.sv
// Bench for fsm_rd_086_chk: three checker configurations share one stimulus
// stream; a per-configuration reference model fills expectation queues that a
// separate monitor drains and compares every cycle.
module tb_fsm_rd_086_chk;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] ptext = 2'b00;
  logic [2:0] rtext = 3'b000;

  logic [2:0] a_exp, b_exp, c_exp;
  logic       a_mis, b_mis, c_mis;
  logic       a_alm, b_alm, c_alm;
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] c_cnt;
  logic       a_lck, b_lck, c_lck;
  logic [2:0] a_st, b_st, c_st;

  always #5 CLK = ~CLK;

  // a: re-locking checker; b: free-running; c: narrow counter, free-running
  fsm_rd_086_chk #(.ERR_W(8), .ALARM_THR(4), .RESYNC(1)) u_a (
    .CLK(CLK), .RST(RST), .en(en), .ptext(ptext), .rtext(rtext), .clr(clr),
    .exp_rtext(a_exp), .mismatch(a_mis), .alarm(a_alm), .err_cnt(a_cnt),
    .locked(a_lck), .shadow_st(a_st));

  fsm_rd_086_chk #(.ERR_W(8), .ALARM_THR(4), .RESYNC(0)) u_b (
    .CLK(CLK), .RST(RST), .en(en), .ptext(ptext), .rtext(rtext), .clr(clr),
    .exp_rtext(b_exp), .mismatch(b_mis), .alarm(b_alm), .err_cnt(b_cnt),
    .locked(b_lck), .shadow_st(b_st));

  fsm_rd_086_chk #(.ERR_W(2), .ALARM_THR(3), .RESYNC(0)) u_c (
    .CLK(CLK), .RST(RST), .en(en), .ptext(ptext), .rtext(rtext), .clr(clr),
    .exp_rtext(c_exp), .mismatch(c_mis), .alarm(c_alm), .err_cnt(c_cnt),
    .locked(c_lck), .shadow_st(c_st));

  typedef struct {
    int st;
    bit locked;
    bit mism;
    int cnt;
    bit alarm;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int p_resync [3] = '{1, 0, 0};
  int p_max    [3] = '{255, 255, 3};
  int p_thr    [3] = '{4, 4, 3};

  int m_st     [3];
  bit m_locked [3];
  bit m_mism   [3];
  int m_cnt    [3];
  bit m_alarm  [3];

  int checks = 0;
  int errors = 0;
  int ctrl   = 0;   // state of the controller being observed (stimulus side)

  // Controller graph written from the state diagram (0=S1 .. 6=S5N, 7=HUNT).
  function automatic int ref_out(input int s);
    case (s)
      2:       return 1;
      3:       return 2;
      4, 5, 6: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_next(input int s, input bit [1:0] p);
    case (s)
      1:       return p[0] ? 3 : 2;
      2:       return p[0] ? 3 : 1;
      3:       return 4;
      4:       return p[1] ? 5 : 3;
      5:       return p[0] ? 0 : 6;
      6:       return p[0] ? 0 : 5;
      default: return 1;
    endcase
  endfunction

  task automatic model_step(input int i, input bit rst_i, input bit en_i,
                            input bit clr_i, input bit [1:0] p, input bit [2:0] r);
    bit fail;
    if (rst_i) begin
      m_st[i] = 0; m_locked[i] = 1; m_mism[i] = 0; m_cnt[i] = 0; m_alarm[i] = 0;
    end else begin
      fail = en_i && m_locked[i] && (int'(r) != ref_out(m_st[i]));
      if (en_i) begin
        if (!m_locked[i]) begin
          if (r == 3'b010) begin m_st[i] = 4; m_locked[i] = 1; end
        end else if (fail && p_resync[i] != 0) begin
          m_st[i] = 7; m_locked[i] = 0;
        end else begin
          m_st[i] = ref_next(m_st[i], p);
        end
      end
      m_mism[i] = fail;
      if (clr_i) begin
        m_cnt[i] = 0; m_alarm[i] = 0;
      end else if (fail) begin
        m_cnt[i] = (m_cnt[i] + 1 > p_max[i]) ? p_max[i] : m_cnt[i] + 1;
        if (m_cnt[i] >= p_thr[i]) m_alarm[i] = 1;
      end
    end
  endtask

  function automatic exp_t snap(input int i);
    exp_t e;
    e.st = m_st[i]; e.locked = m_locked[i]; e.mism = m_mism[i];
    e.cnt = m_cnt[i]; e.alarm = m_alarm[i];
    return e;
  endfunction

  // Drive one cycle's inputs and queue the expected post-edge view.
  task automatic drive(input bit rst_i, input bit en_i, input bit clr_i,
                       input bit [1:0] p, input bit [2:0] r);
    @(negedge CLK);
    RST = rst_i; en = en_i; clr = clr_i; ptext = p; rtext = r;
    for (int i = 0; i < 3; i++) model_step(i, rst_i, en_i, clr_i, p, r);
    qa.push_back(snap(0));
    qb.push_back(snap(1));
    qc.push_back(snap(2));
    if (rst_i) ctrl = 0;
    else if (en_i) ctrl = ref_next(ctrl, p);
  endtask

  // Enabled cycle where rtext follows the controller, optionally corrupted.
  task automatic golden(input bit fault, input bit clr_i);
    bit [1:0] p;
    bit [2:0] r;
    p = 2'($urandom);
    r = 3'(ref_out(ctrl));
    if (fault) r = r ^ 3'b001;
    drive(1'b0, 1'b1, clr_i, p, r);
  endtask

  // Steer the controller into S3 with bounded effort.
  task automatic reach_s3();
    for (int k = 0; k < 12 && ctrl != 3; k++)
      drive(1'b0, 1'b1, 1'b0, 2'b01, 3'(ref_out(ctrl)));
    cmp("reach_s3", "-", ctrl, 3);
  endtask

  task automatic cmp(input string nm, input string inst, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s %s t=%0t actual=%0d required=%0d", nm, inst, $time, act, req);
    end
  endtask

  task automatic check_inst(input string inst, input exp_t e, input int st,
                            input int lck, input int mis, input int cnt,
                            input int alm, input int ex);
    cmp("shadow_st", inst, st, e.st);
    cmp("locked", inst, lck, int'(e.locked));
    cmp("mismatch", inst, mis, int'(e.mism));
    cmp("err_cnt", inst, cnt, e.cnt);
    cmp("alarm", inst, alm, int'(e.alarm));
    cmp("exp_rtext", inst, ex, ref_out(e.st));
  endtask

  // Monitor: after every edge, pop one expectation per instance and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check_inst("a", e, int'(a_st), int'(a_lck), int'(a_mis), int'(a_cnt), int'(a_alm), int'(a_exp));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check_inst("b", e, int'(b_st), int'(b_lck), int'(b_mis), int'(b_cnt), int'(b_alm), int'(b_exp));
      end
      if (qc.size() > 0) begin
        e = qc.pop_front();
        check_inst("c", e, int'(c_st), int'(c_lck), int'(c_mis), int'(c_cnt), int'(c_alm), int'(c_exp));
      end
    end
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

  initial begin
    // reset and golden run
    drive(1'b1, 1'b0, 1'b0, 2'b00, 3'b000);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 3'b000);
    repeat (40) golden(1'b0, 1'b0);

    // single fault in S3, then re-lock on 100, 000, 010
    reach_s3();
    drive(1'b0, 1'b1, 1'b0, 2'($urandom), 3'b011);
    drive(1'b0, 1'b1, 1'b0, 2'($urandom), 3'b100);
    drive(1'b0, 1'b1, 1'b0, 2'($urandom), 3'b000);
    drive(1'b0, 1'b1, 1'b0, 2'($urandom), 3'b010);
    ctrl = 4;
    repeat (20) golden(1'b0, 1'b0);

    // alarm threshold, clear, saturation, clear-vs-mismatch priority
    drive(1'b1, 1'b0, 1'b0, 2'b00, 3'b000);
    for (int k = 0; k < 4; k++) begin
      repeat (2) golden(1'b0, 1'b0);
      golden(1'b1, 1'b0);
    end
    repeat (2) golden(1'b0, 1'b0);
    golden(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      golden(1'b0, 1'b0);
      golden(1'b1, 1'b0);
    end
    golden(1'b1, 1'b1);
    repeat (3) golden(1'b0, 1'b0);

    // enable low with garbage rtext
    repeat (5) drive(1'b0, 1'b0, 1'b0, 2'($urandom), 3'($urandom));
    repeat (5) golden(1'b0, 1'b0);

    // reset while hunting
    drive(1'b1, 1'b0, 1'b0, 2'b00, 3'b000);
    repeat (5) golden(1'b0, 1'b0);
    reach_s3();
    golden(1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 2'($urandom), 3'b100);
    drive(1'b1, 1'b1, 1'b1, 2'($urandom), 3'b010);
    repeat (3) golden(1'b0, 1'b0);

    // randomized mix of enable, faults, clears and resets
    for (int k = 0; k < 300; k++) begin
      bit e_i, f_i, c_i, r_i;
      bit [1:0] p;
      bit [2:0] r;
      e_i = ($urandom % 4) != 0;
      f_i = ($urandom % 6) == 0;
      c_i = e_i && (($urandom % 15) == 0);
      r_i = ($urandom % 60) == 0;
      p = 2'($urandom);
      r = 3'(ref_out(ctrl));
      if (f_i) r = 3'($urandom);
      if (m_locked[0] == 0 && ($urandom % 3) == 0) begin
        r = 3'b010;
        ctrl = 3;
      end
      drive(r_i, e_i, c_i, p, r);
    end

    @(posedge CLK);
    #2;
    cmp("queue_drain", "a", qa.size(), 0);
    cmp("queue_drain", "b", qb.size(), 0);
    cmp("queue_drain", "c", qc.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
